// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: debounced multi-switch front end with round-robin event stream.
// Define BTN_LONG_PRESS_EN to build the long-press counters and events.
module btn_event_ctrl #(
  parameter int NUM_SW         = 4,
  parameter int TICK_DIV       = 12000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  localparam int ID_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_in,
  output logic [NUM_SW-1:0] sw_level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [ID_W-1:0]   evt_id,
  output logic [1:0]        evt_code,
  output logic              evt_ovf
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam int DC_W = $clog2(DEBOUNCE_TICKS + 1);

  logic [NUM_SW-1:0] r_s1, r_s2, r_lvl;
  logic [PS_W-1:0]   r_presc;
  logic [DC_W-1:0]   r_dc [NUM_SW];
  logic [NUM_SW-1:0] r_pp, r_pr;
  logic              r_valid, r_ovf;
  logic [ID_W-1:0]   r_id, r_ptr;
  logic [1:0]        r_code;

  logic              w_tick;
  logic [NUM_SW-1:0] w_rise, w_fall, w_long, w_pl, w_any;
  logic [NUM_SW-1:0] w_sel, w_cp, w_cr, w_drop, w_drop_l;
  logic              w_load, w_found;
  logic [ID_W-1:0]   w_win, w_cand, w_ptr_nx;
  logic [ID_W:0]     w_idx;
  logic [1:0]        w_code;

  assign w_tick = (r_presc == PS_W'(TICK_DIV - 1));

  // two-flop synchronizer per switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw_in;
      r_s2 <= r_s1;
    end
  end

  // shared tick prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else r_presc <= r_presc + PS_W'(1);
  end

  // accept a new level after DEBOUNCE_TICKS consecutive mismatching ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl <= '0;
      for (int i = 0; i < NUM_SW; i++) r_dc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (r_s2[i] == r_lvl[i]) begin
          r_dc[i] <= '0;
        end else if (w_tick) begin
          if (r_dc[i] == DC_W'(DEBOUNCE_TICKS - 1)) begin
            r_lvl[i] <= r_s2[i];
            r_dc[i]  <= '0;
          end else begin
            r_dc[i] <= r_dc[i] + DC_W'(1);
          end
        end
      end
    end
  end

  // level-change events, round-robin winner search and consume masks
  always_comb begin
    w_rise  = '0;
    w_fall  = '0;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (w_tick && (r_s2[i] != r_lvl[i]) &&
          (r_dc[i] == DC_W'(DEBOUNCE_TICKS - 1))) begin
        w_rise[i] = r_s2[i];
        w_fall[i] = ~r_s2[i];
      end
    end
    for (int k = 0; k < NUM_SW; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_SW))
        w_idx = w_idx - (ID_W+1)'(NUM_SW);
      w_cand = w_idx[ID_W-1:0];
      if (!w_found && w_any[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_any    = r_pp | w_pl | r_pr;
  assign w_code   = r_pp[w_win] ? 2'd0 : (w_pl[w_win] ? 2'd2 : 2'd1);
  assign w_load   = !r_valid || evt_ready;
  assign w_sel    = (w_load && w_found) ? (NUM_SW'(1) << w_win) : '0;
  assign w_cp     = w_sel & {NUM_SW{w_code == 2'd0}};
  assign w_cr     = w_sel & {NUM_SW{w_code == 2'd1}};
  assign w_ptr_nx = (w_win == ID_W'(NUM_SW - 1)) ? '0 : w_win + ID_W'(1);
  assign w_drop   = (w_rise & r_pp & ~w_cp) | (w_fall & r_pr & ~w_cr) |
                    w_drop_l;

`ifdef BTN_LONG_PRESS_EN
  localparam int HC_W = $clog2(LONG_TICKS + 1);

  logic [HC_W-1:0]   r_hc [NUM_SW];
  logic [NUM_SW-1:0] r_pl, w_cl;

  assign w_cl     = w_sel & {NUM_SW{w_code == 2'd2}};
  assign w_pl     = r_pl;
  assign w_drop_l = w_long & r_pl & ~w_cl;

  // hold counters saturate so only one long event fires per press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SW; i++) r_hc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (!r_lvl[i]) r_hc[i] <= '0;
        else if (w_tick && (r_hc[i] != HC_W'(LONG_TICKS)))
          r_hc[i] <= r_hc[i] + HC_W'(1);
      end
    end
  end

  // long event on the tick that brings the counter to LONG_TICKS
  always_comb begin
    w_long = '0;
    for (int i = 0; i < NUM_SW; i++)
      w_long[i] = r_lvl[i] && w_tick &&
                  (r_hc[i] == HC_W'(LONG_TICKS - 1));
  end

  // pending long bits; a release discards a stale long of that channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pl <= '0;
    else r_pl <= ((r_pl & ~w_cl) | w_long) & ~w_fall;
  end
`else
  assign w_long   = '0;
  assign w_pl     = '0;
  assign w_drop_l = '0;
`endif

  // pending press/release bits and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pp  <= '0;
      r_pr  <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_pp  <= (r_pp & ~w_cp) | w_rise;
      r_pr  <= (r_pr & ~w_cr) | w_fall;
      r_ovf <= r_ovf | (|w_drop);
    end
  end

  // output slot: reload when empty or being accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_code  <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_id    <= w_win;
        r_code  <= w_code;
        r_ptr   <= w_ptr_nx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign sw_level  = r_lvl;
  assign evt_valid = r_valid;
  assign evt_id    = r_id;
  assign evt_code  = r_code;
  assign evt_ovf   = r_ovf;

endmodule
